branch_target_unit: RTL and testbench
=====================================

BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

Interface
REQ-001 Parameter XLEN, default 32, address and operand width; legal values 32 and 64.
REQ-002 Parameter CNT_W, default 16, width of the redirect counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 flush  input  1  discards all buffered results.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit can accept a request this cycle.
REQ-008 pc_control  input  2  operation: 00 SEQ, 01 JAL, 10 JALR, 11 BRANCH.
REQ-009 br_taken  input  1  branch outcome; used only for BRANCH.
REQ-010 pc  input  XLEN  address of the current instruction.
REQ-011 imm  input  XLEN  sign-extended immediate, already byte-scaled.
REQ-012 rs1  input  XLEN  register operand for JALR.
REQ-013 out_valid  output  1  result present at buffer head.
REQ-014 out_ready  input  1  consumer accepts the head result.
REQ-015 next_pc  output  XLEN  computed next-instruction address.
REQ-016 redirect  output  1  next_pc differs from the sequential path (JAL, JALR, taken BRANCH).
REQ-017 misaligned  output  1  redirect target violates alignment.
REQ-018 redirect_cnt  output  CNT_W  saturating count of accepted redirects.

Function
REQ-019 Request accepted when in_valid and in_ready are both high in the same cycle; result transferred when out_valid and out_ready are both high.
REQ-020 Target arithmetic modulo 2^XLEN, no overflow flag: SEQ -> pc+4; JAL -> pc+imm; JALR -> (rs1+imm) with bit 0 cleared; BRANCH -> br_taken ? pc+imm : pc+4.
REQ-021 Result (next_pc, redirect, misaligned) is computed from accepted inputs and written into a 2-entry FIFO output buffer; latency 1 cycle: out_valid rises the cycle after acceptance when the buffer was empty.
REQ-022 in_ready = buffer count < 2; it depends on registered state only, never combinationally on out_ready.
REQ-023 Buffer occupancy states EMPTY, ONE, FULL. Transitions: push only -> next state; pop only -> previous state; push and pop together in ONE -> ONE; in FULL only a pop is possible.
REQ-024 Results leave in acceptance order; outputs hold stable while out_valid is high and out_ready is low.
REQ-025 misaligned is asserted only when redirect is high and target alignment rule (REQ-034/035) fails; SEQ and not-taken BRANCH never flag.
REQ-026 redirect_cnt increments by 1 on each accepted request producing redirect=1, including misaligned ones; it holds at 2^CNT_W-1 once reached.
REQ-027 flush high: buffer becomes EMPTY next cycle, any request accepted in that cycle is discarded, redirect_cnt unaffected except that it still counts that cycle's accepted redirect.
REQ-028 flush and rst together: rst takes priority.
REQ-029 Unused buffer entries drive no visible state; next_pc/redirect/misaligned are don't-care while out_valid is low.

Reset
REQ-030 rst high: buffer EMPTY, out_valid 0, redirect_cnt 0, next_pc 0, redirect 0, misaligned 0, starting the cycle after rst is sampled.
REQ-031 in_ready is 0 while rst is high; 1 in the first cycle after rst deasserts.
REQ-032 Reset asserted mid-operation drops all buffered results; nothing is transferred in the reset cycle.
REQ-033 No state depends on initial values other than reset.

Configuration
REQ-034 Macro BTU_RVC_EN defined: compressed support; redirect target is misaligned when bit 0 is 1 (2-byte alignment).
REQ-035 BTU_RVC_EN undefined: redirect target is misaligned when bits [1:0] are nonzero (4-byte alignment); SEQ increment stays +4 in both builds.

Verification
REQ-036 XLEN=32, JAL pc=0x1000 imm=0xFFFFFFF0, out_ready=1 -> one cycle later next_pc=0x00000FF0, redirect=1, misaligned=0, redirect_cnt=1.
REQ-037 JALR rs1=0x2003 imm=0x4 -> next_pc=0x2006, redirect=1; misaligned=1 without BTU_RVC_EN, 0 with BTU_RVC_EN.
REQ-038 BRANCH pc=0x100 imm=0x20 br_taken=0 -> next_pc=0x104, redirect=0, count unchanged; br_taken=1 -> next_pc=0x120, redirect=1.
REQ-039 out_ready=0, three back-to-back requests -> in_ready drops after second acceptance, third held; release out_ready -> results emerge in order, third accepted one cycle after first pop.
REQ-040 Buffer FULL, assert flush for one cycle -> out_valid=0 next cycle, in_ready=1; rst mid-stream -> all outputs zero, redirect_cnt=0.
REQ-041 CNT_W=2, five accepted JALs -> redirect_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/branch_target_unit.sv
// Next-PC computation unit with a 2-entry result FIFO and saturating redirect counter.
// Optional macro BTU_RVC_EN relaxes redirect-target alignment to 2 bytes (compressed ISA).
module branch_target_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       pc_control,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  next_pc,
    output logic             redirect,
    output logic             misaligned,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            redirect;
        logic            misaligned;
    } entry_t;

    localparam logic [1:0]       OP_SEQ    = 2'b00;
    localparam logic [1:0]       OP_JAL    = 2'b01;
    localparam logic [1:0]       OP_JALR   = 2'b10;
    localparam logic [1:0]       OP_BRANCH = 2'b11;
    localparam logic [XLEN-1:0]  SEQ_INC   = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0]  LSB_CLR   = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic target_misaligned(input logic [XLEN-1:0] target);
`ifdef BTU_RVC_EN
        return target[0];
`else
        return |target[1:0];
`endif
    endfunction

    occ_e             state_q, state_d;
    entry_t           slot0_q, slot0_d;
    entry_t           slot1_q, slot1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    entry_t           new_s;
    logic             push_s;
    logic             pop_s;

    // in_ready comes from registered occupancy only, gated while reset is held
    assign in_ready   = ~rst & (state_q != ST_FULL);
    assign out_valid  = (state_q != ST_EMPTY);
    assign push_s     = in_valid & in_ready;
    assign pop_s      = out_valid & out_ready;

    assign next_pc      = slot0_q.pc;
    assign redirect     = slot0_q.redirect;
    assign misaligned   = slot0_q.misaligned;
    assign redirect_cnt = cnt_q;

    // Target arithmetic for the incoming request
    always_comb begin
        new_s = '0;
        case (pc_control)
            OP_SEQ: begin
                new_s.pc       = pc + SEQ_INC;
                new_s.redirect = 1'b0;
            end
            OP_JAL: begin
                new_s.pc       = pc + imm;
                new_s.redirect = 1'b1;
            end
            OP_JALR: begin
                new_s.pc       = (rs1 + imm) & LSB_CLR;
                new_s.redirect = 1'b1;
            end
            OP_BRANCH: begin
                if (br_taken) begin
                    new_s.pc       = pc + imm;
                    new_s.redirect = 1'b1;
                end else begin
                    new_s.pc       = pc + SEQ_INC;
                    new_s.redirect = 1'b0;
                end
            end
            default: begin
                new_s.pc       = pc + SEQ_INC;
                new_s.redirect = 1'b0;
            end
        endcase
        new_s.misaligned = new_s.redirect & target_misaligned(new_s.pc);
    end

    // Occupancy FSM, FIFO slot update and redirect counter next-state
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;

        // Counter sees accepted redirects even in a flush cycle
        if (push_s && new_s.redirect && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        if (flush) begin
            state_d = ST_EMPTY;
            slot0_d = '0;
            slot1_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        slot0_d = new_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        slot0_d = new_s;
                        state_d = ST_ONE;
                    end else if (push_s) begin
                        slot1_d = new_s;
                        state_d = ST_FULL;
                    end else if (pop_s) begin
                        slot0_d = '0;
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        slot0_d = slot1_q;
                        slot1_d = '0;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    slot0_d = '0;
                    slot1_d = '0;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over flush
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed self-checking bench for branch_target_unit; a second CNT_W=2 instance
// shares the stimulus to exercise counter saturation.
module tb_branch_target_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  pc_control;
    logic        br_taken;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] next_pc;
    logic        redirect;
    logic        misaligned;
    logic [15:0] redirect_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_next_pc;
    logic        s_redirect;
    logic        s_misaligned;
    logic [1:0]  s_redirect_cnt;

    int checks;
    int errors;
    int exp_cnt;

`ifdef BTU_RVC_EN
    localparam logic MIS_JALR = 1'b0;
    localparam logic MIS_BR2  = 1'b0;
`else
    localparam logic MIS_JALR = 1'b1;
    localparam logic MIS_BR2  = 1'b1;
`endif

    branch_target_unit #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_control(pc_control), .br_taken(br_taken), .pc(pc), .imm(imm), .rs1(rs1),
        .out_valid(out_valid), .out_ready(out_ready), .next_pc(next_pc),
        .redirect(redirect), .misaligned(misaligned), .redirect_cnt(redirect_cnt)
    );

    branch_target_unit #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .pc_control(pc_control), .br_taken(br_taken), .pc(pc), .imm(imm), .rs1(rs1),
        .out_valid(s_out_valid), .out_ready(out_ready), .next_pc(s_next_pc),
        .redirect(s_redirect), .misaligned(s_misaligned), .redirect_cnt(s_redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ctrl, input logic taken,
                         input logic [31:0] p, input logic [31:0] i, input logic [31:0] r);
        in_valid   = 1'b1;
        pc_control = ctrl;
        br_taken   = taken;
        pc         = p;
        imm        = i;
        rs1        = r;
    endtask

    task automatic check_head(input string tag, input logic [31:0] exp_pc,
                              input logic exp_red, input logic exp_mis);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_pc"}, {32'd0, next_pc}, {32'd0, exp_pc});
        check({tag, "_red"}, {63'd0, redirect}, {63'd0, exp_red});
        check({tag, "_mis"}, {63'd0, misaligned}, {63'd0, exp_mis});
        check({tag, "_cnt"}, {48'd0, redirect_cnt}, 64'(exp_cnt));
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
        checks = 0; errors = 0; exp_cnt = 0;
        clk = 1'b0; rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pc_control = 2'b00; br_taken = 1'b0; pc = 32'd0; imm = 32'd0; rs1 = 32'd0;

        // reset state
        tick();
        tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_next_pc", {32'd0, next_pc}, 64'd0);
        check("rst_cnt", {48'd0, redirect_cnt}, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // five JALs back to back; first one is the pc=0x1000 imm=-16 case
        drive(2'b01, 1'b0, 32'h0000_1000, 32'hFFFF_FFF0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_cnt = exp_cnt + 1;
            check_head("jal", 32'h0000_0FF0, 1'b1, 1'b0);
            check("sat_cnt", {62'd0, s_redirect_cnt}, {62'd0, sat_exp[k]});
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", {63'd0, out_valid}, 64'd0);

        // JALR clears bit 0; alignment flag depends on build
        drive(2'b10, 1'b0, 32'd0, 32'h0000_0004, 32'h0000_2003);
        tick();
        exp_cnt = exp_cnt + 1;
        check_head("jalr", 32'h0000_2006, 1'b1, MIS_JALR);

        // SEQ never flags, even from an odd pc
        drive(2'b00, 1'b0, 32'h0000_0011, 32'h0000_0020, 32'd0);
        tick();
        check_head("seq", 32'h0000_0015, 1'b0, 1'b0);

        drive(2'b11, 1'b0, 32'h0000_0100, 32'h0000_0020, 32'd0);
        tick();
        check_head("br_nt", 32'h0000_0104, 1'b0, 1'b0);

        drive(2'b11, 1'b1, 32'h0000_0100, 32'h0000_0020, 32'd0);
        tick();
        exp_cnt = exp_cnt + 1;
        check_head("br_t", 32'h0000_0120, 1'b1, 1'b0);

        drive(2'b11, 1'b1, 32'h0000_0100, 32'h0000_0002, 32'd0);
        tick();
        exp_cnt = exp_cnt + 1;
        check_head("br_t2", 32'h0000_0102, 1'b1, MIS_BR2);

        // wrap modulo 2^32
        drive(2'b01, 1'b0, 32'hFFFF_FFFC, 32'h0000_0008, 32'd0);
        tick();
        exp_cnt = exp_cnt + 1;
        check_head("jal_wrap", 32'h0000_0004, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();
        check("empty_valid", {63'd0, out_valid}, 64'd0);

        // backpressure: third request held until the first pop
        out_ready = 1'b0;
        drive(2'b00, 1'b0, 32'h0000_0200, 32'd0, 32'd0);
        tick();
        drive(2'b00, 1'b0, 32'h0000_0300, 32'd0, 32'd0);
        check("bp_ready1", {63'd0, in_ready}, 64'd1);
        tick();
        check("bp_full_ready", {63'd0, in_ready}, 64'd0);
        drive(2'b01, 1'b0, 32'h0000_0400, 32'h0000_0040, 32'd0);
        tick();
        check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
        check_head("bp_hold", 32'h0000_0204, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        check_head("bp_second", 32'h0000_0304, 1'b0, 1'b0);
        check("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 1;
        check_head("bp_third", 32'h0000_0440, 1'b1, 1'b0);
        tick();
        check("bp_drained", {63'd0, out_valid}, 64'd0);

        // flush with buffer full
        out_ready = 1'b0;
        drive(2'b00, 1'b0, 32'h0000_0500, 32'd0, 32'd0);
        tick();
        tick();
        in_valid = 1'b0;
        check("fl_full", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", {63'd0, out_valid}, 64'd0);
        check("fl_ready", {63'd0, in_ready}, 64'd1);

        // flush discards the accepted request but still counts its redirect
        flush = 1'b1;
        drive(2'b01, 1'b0, 32'h0000_0600, 32'h0000_0010, 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 1;
        check("fl_acc_valid", {63'd0, out_valid}, 64'd0);
        check("fl_acc_cnt", {48'd0, redirect_cnt}, 64'(exp_cnt));

        // reset mid-stream, with flush also high
        drive(2'b01, 1'b0, 32'h0000_0700, 32'h0000_0010, 32'd0);
        tick();
        tick();
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 2;
        check("pre_rst_cnt", {48'd0, redirect_cnt}, 64'(exp_cnt));
        check("pre_rst_sat", {62'd0, s_redirect_cnt}, 64'd3);
        rst = 1'b1;
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_pc", {32'd0, next_pc}, 64'd0);
        check("mid_rst_red", {62'd0, redirect, misaligned}, 64'd0);
        check("mid_rst_cnt", {48'd0, redirect_cnt}, 64'd0);
        check("mid_rst_sat", {62'd0, s_redirect_cnt}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check("after_rst_ready", {63'd0, in_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
